// File: rtl/mode_display_scheduler_if.sv
// Signal bundle between the mode scheduler and the watch/stopwatch/cook functions,
// buttons and the shared FND/LED board outputs.
interface mode_display_scheduler_if;
  logic       btn_mode_pedge;
  logic [2:0] btn_pedge;
  logic       btn_alarm_off_pedge;
  logic       alarm_req;
  logic       stop_running;
  logic       cook_running;
  logic [7:0] seg_watch;
  logic [7:0] seg_stop;
  logic [7:0] seg_cook;
  logic [3:0] com_watch;
  logic [3:0] com_stop;
  logic [3:0] com_cook;
  logic [4:0] led_watch;
  logic [4:0] led_stop;
  logic [4:0] led_cook;

  logic [2:0] mode;
  logic [2:0] btn_watch;
  logic [2:0] btn_stop;
  logic [2:0] btn_cook;
  logic       alarm_off;
  logic [7:0] seg_7;
  logic [3:0] com;
  logic [4:0] led;
  logic       alarm_view;

  // Environment side: buttons, function status and private display copies.
  modport master (
    output btn_mode_pedge, btn_pedge, btn_alarm_off_pedge, alarm_req,
    output stop_running, cook_running,
    output seg_watch, seg_stop, seg_cook, com_watch, com_stop, com_cook,
    output led_watch, led_stop, led_cook,
    input  mode, btn_watch, btn_stop, btn_cook, alarm_off,
    input  seg_7, com, led, alarm_view
  );

  // Scheduler side.
  modport slave (
    input  btn_mode_pedge, btn_pedge, btn_alarm_off_pedge, alarm_req,
    input  stop_running, cook_running,
    input  seg_watch, seg_stop, seg_cook, com_watch, com_stop, com_cook,
    input  led_watch, led_stop, led_cook,
    output mode, btn_watch, btn_stop, btn_cook, alarm_off,
    output seg_7, com, led, alarm_view
  );
endinterface

// File: rtl/mode_display_scheduler.sv
// Mode controller for the multi-function clock: mode sequencing, button gating,
// shared display mux, cook-alarm preemption with blink, and idle return to watch.
module mode_display_scheduler #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int IDLE_SEC  = 30,
  parameter int BLINK_DIV = 25_000_000
) (
  input logic                      clk,
  input logic                      reset_p,
  mode_display_scheduler_if.slave  bus_if
);

  localparam int TICK_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int IDLE_W  = (IDLE_SEC > 0) ? $clog2(IDLE_SEC + 1) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLK_HZ - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(IDLE_SEC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // One-hot; the low three bits double as the mode output outside the alarm view.
  localparam logic [3:0] S_WATCH = 4'b0001;
  localparam logic [3:0] S_STOP  = 4'b0010;
  localparam logic [3:0] S_COOK  = 4'b0100;
  localparam logic [3:0] S_ALARM = 4'b1000;

  logic [3:0]         state_q, state_d;
  logic [3:0]         saved_q, saved_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic [7:0]         seg_q, seg_d;
  logic [3:0]         com_q, com_d;
  logic [4:0]         led_q, led_d;
  logic               alarm_off_q;
  logic [2:0]         btn_route [3];

  logic tick;
  logic idle_en;
  logic idle_hit;
  logic any_btn;
  logic state_change;
  logic deliver;

  assign tick         = (tick_cnt_q == TICK_LAST);
  assign any_btn      = (|bus_if.btn_pedge) | bus_if.btn_mode_pedge | bus_if.btn_alarm_off_pedge;
  assign state_change = (state_d != state_q);
  assign idle_en      = ((state_q == S_STOP) && !bus_if.stop_running) ||
                        ((state_q == S_COOK) && !bus_if.cook_running);
  assign idle_hit     = (IDLE_SEC != 0) && (idle_cnt_q == IDLE_LIMIT);

  // Alarm entry outranks idle return, which outranks the mode button.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    case (state_q)
      S_WATCH, S_STOP: begin
        if (bus_if.alarm_req) begin
          state_d = S_ALARM;
          saved_d = state_q;
        end else if (idle_hit) begin
          state_d = S_WATCH;
        end else if (bus_if.btn_mode_pedge) begin
          state_d = (state_q == S_WATCH) ? S_STOP : S_COOK;
        end
      end
      S_COOK: begin
        if (!bus_if.alarm_req) begin
          if (idle_hit || bus_if.btn_mode_pedge) begin
            state_d = S_WATCH;
          end
        end
      end
      S_ALARM: begin
        if (!bus_if.alarm_req) begin
          state_d = saved_q;
        end
      end
      default: begin
        state_d = S_WATCH;
      end
    endcase
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (any_btn || state_change || !idle_en) begin
      idle_cnt_d = '0;
    end else if (tick && (idle_cnt_q != IDLE_LIMIT)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  // Blink runs only while the alarm view persists; leaving it restores the visible phase.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_q == S_ALARM) && (state_d == S_ALARM)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_d     = blink_q;
      end
    end
  end

  always_comb begin
    seg_d = bus_if.seg_cook;
    com_d = bus_if.com_cook;
    led_d = bus_if.led_cook;
    case (state_q)
      S_WATCH: begin
        seg_d = bus_if.seg_watch;
        com_d = bus_if.com_watch;
        led_d = bus_if.led_watch;
      end
      S_STOP: begin
        seg_d = bus_if.seg_stop;
        com_d = bus_if.com_stop;
        led_d = bus_if.led_stop;
      end
      default: begin
      end
    endcase
    if ((state_q == S_ALARM) && blink_q) begin
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= S_WATCH;
      saved_q     <= S_WATCH;
      tick_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      seg_q       <= 8'hFF;
      com_q       <= 4'hF;
      led_q       <= 5'd0;
      alarm_off_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      tick_cnt_q  <= tick_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      seg_q       <= seg_d;
      com_q       <= com_d;
      led_q       <= led_d;
      alarm_off_q <= bus_if.btn_alarm_off_pedge;
    end
  end

  // A user press landing with a mode press or any state change goes to nobody.
  assign deliver = !bus_if.btn_mode_pedge && !state_change;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_route
      logic [2:0] route_q;
      always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
          route_q <= 3'b000;
        end else begin
          route_q <= (state_q[gi] && deliver) ? bus_if.btn_pedge : 3'b000;
        end
      end
      assign btn_route[gi] = route_q;
    end
  endgenerate

  assign bus_if.mode       = (state_q == S_ALARM) ? 3'b100 : state_q[2:0];
  assign bus_if.alarm_view = (state_q == S_ALARM);
  assign bus_if.btn_watch  = btn_route[0];
  assign bus_if.btn_stop   = btn_route[1];
  assign bus_if.btn_cook   = btn_route[2];
  assign bus_if.alarm_off  = alarm_off_q;
  assign bus_if.seg_7      = seg_q;
  assign bus_if.com        = com_q;
  assign bus_if.led        = led_q;

endmodule

// File: tb/tb_mode_display_scheduler.sv
// Directed bench for mode_display_scheduler with small timing parameters.
module tb_mode_display_scheduler;

  logic clk;
  logic reset_p;
  int   errors;
  int   checks;

  mode_display_scheduler_if bus ();

  mode_display_scheduler #(
    .CLK_HZ   (10),
    .IDLE_SEC (3),
    .BLINK_DIV(4)
  ) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press_mode();
    bus.btn_mode_pedge = 1'b1;
    step(1);
    bus.btn_mode_pedge = 1'b0;
  endtask

  task automatic check_btns_zero(input string tag);
    check({tag, "_watch"}, 32'(bus.btn_watch), 32'h0);
    check({tag, "_stop"},  32'(bus.btn_stop),  32'h0);
    check({tag, "_cook"},  32'(bus.btn_cook),  32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_p = 1'b1;
    bus.btn_mode_pedge      = 1'b0;
    bus.btn_pedge           = 3'b000;
    bus.btn_alarm_off_pedge = 1'b0;
    bus.alarm_req           = 1'b0;
    bus.stop_running        = 1'b1;
    bus.cook_running        = 1'b1;
    bus.seg_watch = 8'hA1; bus.com_watch = 4'hE; bus.led_watch = 5'h01;
    bus.seg_stop  = 8'hB2; bus.com_stop  = 4'hD; bus.led_stop  = 5'h02;
    bus.seg_cook  = 8'hC3; bus.com_cook  = 4'hB; bus.led_cook  = 5'h04;

    step(3);
    check("rst_mode", 32'(bus.mode), 32'h1);
    check("rst_alarm_view", 32'(bus.alarm_view), 32'h0);
    check("rst_alarm_off", 32'(bus.alarm_off), 32'h0);
    check_btns_zero("rst_btn");
    reset_p = 1'b0;

    // Mode sequencing and display follow
    step(1);
    check("watch_seg", 32'(bus.seg_7), 32'hA1);
    press_mode();
    check("mode_stop", 32'(bus.mode), 32'h2);
    step(1);
    check("stop_seg", 32'(bus.seg_7), 32'hB2);
    check("stop_com", 32'(bus.com), 32'hD);
    press_mode();
    check("mode_cook", 32'(bus.mode), 32'h4);
    step(1);
    check("cook_seg", 32'(bus.seg_7), 32'hC3);
    check("cook_led", 32'(bus.led), 32'h04);
    press_mode();
    check("mode_watch", 32'(bus.mode), 32'h1);
    step(1);
    check("watch_seg2", 32'(bus.seg_7), 32'hA1);
    check("watch_led", 32'(bus.led), 32'h01);

    // Button routing in STOP
    press_mode();
    check("mode_stop2", 32'(bus.mode), 32'h2);
    bus.btn_pedge = 3'b001;
    step(1);
    bus.btn_pedge = 3'b000;
    check("route_stop", 32'(bus.btn_stop), 32'h1);
    check("route_watch0", 32'(bus.btn_watch), 32'h0);
    check("route_cook0", 32'(bus.btn_cook), 32'h0);
    step(1);
    check("route_stop_clear", 32'(bus.btn_stop), 32'h0);
    bus.btn_pedge = 3'b010;
    bus.btn_mode_pedge = 1'b1;
    step(1);
    bus.btn_pedge = 3'b000;
    bus.btn_mode_pedge = 1'b0;
    check("drop_mode", 32'(bus.mode), 32'h4);
    check_btns_zero("drop_btn");
    press_mode();
    press_mode();
    check("back_stop", 32'(bus.mode), 32'h2);

    // Alarm preemption from STOP with blink
    bus.alarm_req = 1'b1;
    step(1);
    check("alarm_mode", 32'(bus.mode), 32'h4);
    check("alarm_view", 32'(bus.alarm_view), 32'h1);
    step(1);
    check("blink_vis1", 32'(bus.seg_7), 32'hC3);
    step(3);
    check("blink_vis4", 32'(bus.seg_7), 32'hC3);
    step(1);
    check("blink_off1", 32'(bus.seg_7), 32'hFF);
    check("blink_com", 32'(bus.com), 32'hB);
    step(3);
    check("blink_off4", 32'(bus.seg_7), 32'hFF);
    step(1);
    check("blink_vis_again", 32'(bus.seg_7), 32'hC3);
    bus.btn_pedge = 3'b001;
    bus.btn_alarm_off_pedge = 1'b1;
    bus.btn_mode_pedge = 1'b1;
    step(1);
    bus.btn_pedge = 3'b000;
    bus.btn_alarm_off_pedge = 1'b0;
    bus.btn_mode_pedge = 1'b0;
    check_btns_zero("alarm_block");
    check("alarm_off_fwd", 32'(bus.alarm_off), 32'h1);
    check("alarm_mode_ignored", 32'(bus.mode), 32'h4);
    step(1);
    check("alarm_off_clear", 32'(bus.alarm_off), 32'h0);
    bus.alarm_req = 1'b0;
    step(1);
    check("restore_stop", 32'(bus.mode), 32'h2);
    check("restore_view", 32'(bus.alarm_view), 32'h0);
    step(1);
    check("restore_seg", 32'(bus.seg_7), 32'hB2);

    // Alarm and mode press together in WATCH
    press_mode();
    press_mode();
    check("pre_watch", 32'(bus.mode), 32'h1);
    bus.alarm_req = 1'b1;
    bus.btn_mode_pedge = 1'b1;
    step(1);
    bus.btn_mode_pedge = 1'b0;
    check("race_view", 32'(bus.alarm_view), 32'h1);
    step(1);
    bus.alarm_req = 1'b0;
    step(1);
    check("race_restore", 32'(bus.mode), 32'h1);

    // Idle return from COOK
    press_mode();
    press_mode();
    check("idle_in_cook", 32'(bus.mode), 32'h4);
    bus.cook_running = 1'b0;
    step(15);
    check("idle_early", 32'(bus.mode), 32'h4);
    step(20);
    check("idle_return", 32'(bus.mode), 32'h1);
    press_mode();
    press_mode();
    bus.cook_running = 1'b1;
    step(60);
    check("idle_running_hold", 32'(bus.mode), 32'h4);

    // Alarm while in COOK: no alarm view
    bus.alarm_req = 1'b1;
    step(1);
    check("cook_alarm_mode", 32'(bus.mode), 32'h4);
    check("cook_alarm_view", 32'(bus.alarm_view), 32'h0);
    bus.alarm_req = 1'b0;
    press_mode();
    check("cook_exit", 32'(bus.mode), 32'h1);

    // Reset in the middle of an alarm
    bus.alarm_req = 1'b1;
    step(1);
    check("pre_reset_view", 32'(bus.alarm_view), 32'h1);
    reset_p = 1'b1;
    #1;
    check("rst_async_mode", 32'(bus.mode), 32'h1);
    check("rst_async_view", 32'(bus.alarm_view), 32'h0);
    check_btns_zero("rst_async_btn");
    step(1);
    reset_p = 1'b0;
    step(1);
    check("reenter_view", 32'(bus.alarm_view), 32'h1);
    check("reenter_mode", 32'(bus.mode), 32'h4);
    bus.alarm_req = 1'b0;
    step(1);
    check("reenter_restore", 32'(bus.mode), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
